// File: rtl/ps2_mouse_pkt.sv
// PS/2 mouse receiver: synchronises the PS/2 lines, deframes 11-bit frames,
// assembles 3- or 4-byte movement packets and tracks a clamped cursor.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx_en           receive enable (low holds the receiver idle)
//   ps2_clk/data    raw PS/2 lines, asynchronous to clk
//   pos_x/pos_y     clamped cursor position (Y grows screen-down)
//   buttons         {middle, right, left} from the last accepted packet
//   wheel           signed wheel delta (0 for 3-byte packets)
//   pkt_valid       one-cycle pulse per accepted packet
//   err_*           one-cycle parity / frame / timeout error pulses
//   ack_seen        sticky, set by a received 0xFA byte
module ps2_mouse_pkt #(
  parameter int unsigned PKT_BYTES = 3,
  parameter int unsigned POS_W     = 10,
  parameter int unsigned X_MAX     = 639,
  parameter int unsigned Y_MAX     = 479,
  parameter int unsigned TIMEOUT   = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_en,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic [2:0]       buttons,
  output logic [3:0]       wheel,
  output logic             pkt_valid,
  output logic             err_parity,
  output logic             err_frame,
  output logic             err_timeout,
  output logic             ack_seen
);

  localparam int unsigned PW    = POS_W + 2;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned IDX_W = 2;
  localparam logic signed [PW-1:0] X_MAX_S = PW'(X_MAX);
  localparam logic signed [PW-1:0] Y_MAX_S = PW'(Y_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_e;

  logic             clk_meta_q, clk_sync_q, clk_prev_q;
  logic             dat_meta_q, dat_sync_q;
  state_e           state_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             par_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       b0_q, b1_q, b2_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [POS_W-1:0] pos_x_q, pos_y_q;
  logic [2:0]       buttons_q;
  logic [3:0]       wheel_q;
  logic             pkt_valid_q, err_parity_q, err_frame_q, err_timeout_q, ack_seen_q;

  logic             fall_c;
  logic             par_ok_c;
  logic [7:0]       b2_c;
  logic [3:0]       wheel_c;
  logic signed [8:0]    dx9, dy9;
  logic signed [PW-1:0] sum_x, sum_y;
  logic [POS_W-1:0] pos_x_d, pos_y_d;

  assign fall_c   = clk_prev_q & ~clk_sync_q;
  assign par_ok_c = ^{shift_q, par_q};
  // The final packet byte is still in the shift register at the stop edge.
  assign b2_c     = (PKT_BYTES == 4) ? b2_q : shift_q;
  assign wheel_c  = (PKT_BYTES == 4) ? shift_q[3:0] : 4'd0;

  // Cursor update: signed deltas, overflowed axis ignored, clamp to screen.
  always_comb begin
    dx9     = b0_q[6] ? 9'sd0 : {b0_q[4], b1_q};
    dy9     = b0_q[7] ? 9'sd0 : {b0_q[5], b2_c};
    sum_x   = $signed({2'b00, pos_x_q}) + PW'(dx9);
    sum_y   = $signed({2'b00, pos_y_q}) - PW'(dy9);
    pos_x_d = sum_x[POS_W-1:0];
    pos_y_d = sum_y[POS_W-1:0];
    if (sum_x[PW-1])          pos_x_d = '0;
    else if (sum_x > X_MAX_S) pos_x_d = POS_W'(X_MAX);
    if (sum_y[PW-1])          pos_y_d = '0;
    else if (sum_y > Y_MAX_S) pos_y_d = POS_W'(Y_MAX);
  end

  // Synchroniser, frame FSM, packet assembly and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q    <= 1'b1;
      clk_sync_q    <= 1'b1;
      clk_prev_q    <= 1'b1;
      dat_meta_q    <= 1'b1;
      dat_sync_q    <= 1'b1;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      idx_q         <= '0;
      b0_q          <= '0;
      b1_q          <= '0;
      b2_q          <= '0;
      to_cnt_q      <= '0;
      pos_x_q       <= POS_W'(X_MAX / 2);
      pos_y_q       <= POS_W'(Y_MAX / 2);
      buttons_q     <= '0;
      wheel_q       <= '0;
      pkt_valid_q   <= 1'b0;
      err_parity_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      ack_seen_q    <= 1'b0;
    end else begin
      clk_meta_q    <= ps2_clk;
      clk_sync_q    <= clk_meta_q;
      clk_prev_q    <= clk_sync_q;
      dat_meta_q    <= ps2_data;
      dat_sync_q    <= dat_meta_q;
      pkt_valid_q   <= 1'b0;
      err_parity_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;

      if (!rx_en) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        idx_q     <= '0;
        to_cnt_q  <= '0;
      end else if (fall_c) begin
        // A falling edge wins over a coincident timeout.
        to_cnt_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (!dat_sync_q) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
          ST_DATA: begin
            shift_q   <= {dat_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            par_q   <= dat_sync_q;
            state_q <= ST_STOP;
          end
          default: begin
            state_q <= ST_IDLE;
            if (!dat_sync_q) begin
              err_frame_q <= 1'b1;
              idx_q       <= '0;
            end else if (!par_ok_c) begin
              err_parity_q <= 1'b1;
              idx_q        <= '0;
            end else if (idx_q == '0) begin
              // 0xFA is a command ack; a header without bit 3 means lost sync.
              if (shift_q == 8'hFA) begin
                ack_seen_q <= 1'b1;
              end else if (!shift_q[3]) begin
                err_frame_q <= 1'b1;
              end else begin
                b0_q  <= shift_q;
                idx_q <= IDX_W'(1);
              end
            end else if (idx_q == IDX_W'(PKT_BYTES - 1)) begin
              pkt_valid_q <= 1'b1;
              pos_x_q     <= pos_x_d;
              pos_y_q     <= pos_y_d;
              buttons_q   <= b0_q[2:0];
              wheel_q     <= wheel_c;
              idx_q       <= '0;
            end else begin
              if (idx_q == IDX_W'(1)) b1_q <= shift_q;
              else                    b2_q <= shift_q;
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        endcase
      end else if (state_q != ST_IDLE) begin
        if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          err_timeout_q <= 1'b1;
          state_q       <= ST_IDLE;
          idx_q         <= '0;
          to_cnt_q      <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
        end
      end
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign buttons     = buttons_q;
  assign wheel       = wheel_q;
  assign pkt_valid   = pkt_valid_q;
  assign err_parity  = err_parity_q;
  assign err_frame   = err_frame_q;
  assign err_timeout = err_timeout_q;
  assign ack_seen    = ack_seen_q;

endmodule

// File: tb/tb_ps2_mouse_pkt.sv
// Directed bench for ps2_mouse_pkt: a 3-byte and a 4-byte instance share the
// PS/2 lines, each with its own receive enable.
`timescale 1ns/1ps
module tb_ps2_mouse_pkt;

  localparam int unsigned TO = 200;

  logic clk = 1'b0;
  logic rst, rx_en3, rx_en4, ps2_clk, ps2_data;

  logic [9:0] pos_x3, pos_y3, pos_x4, pos_y4;
  logic [2:0] buttons3, buttons4;
  logic [3:0] wheel3, wheel4;
  logic pkt_valid3, err_parity3, err_frame3, err_timeout3, ack_seen3;
  logic pkt_valid4, err_parity4, err_frame4, err_timeout4, ack_seen4;

  int v3 = 0, pe3 = 0, fe3 = 0, to3 = 0;
  int v4 = 0, pe4 = 0, fe4 = 0, to4 = 0;
  int n_assert = 0, n_fail = 0;

  ps2_mouse_pkt #(.PKT_BYTES(3), .POS_W(10), .X_MAX(639), .Y_MAX(479), .TIMEOUT(TO)) dut3 (
    .clk(clk), .rst(rst), .rx_en(rx_en3), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .pos_x(pos_x3), .pos_y(pos_y3), .buttons(buttons3), .wheel(wheel3),
    .pkt_valid(pkt_valid3), .err_parity(err_parity3), .err_frame(err_frame3),
    .err_timeout(err_timeout3), .ack_seen(ack_seen3)
  );

  ps2_mouse_pkt #(.PKT_BYTES(4), .POS_W(10), .X_MAX(639), .Y_MAX(479), .TIMEOUT(TO)) dut4 (
    .clk(clk), .rst(rst), .rx_en(rx_en4), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .pos_x(pos_x4), .pos_y(pos_y4), .buttons(buttons4), .wheel(wheel4),
    .pkt_valid(pkt_valid4), .err_parity(err_parity4), .err_frame(err_frame4),
    .err_timeout(err_timeout4), .ack_seen(ack_seen4)
  );

  always #5 clk = ~clk;

  // Pulse counters; a stuck-high pulse shows up as an oversized count.
  always @(negedge clk) begin
    if (pkt_valid3)   v3++;
    if (err_parity3)  pe3++;
    if (err_frame3)   fe3++;
    if (err_timeout3) to3++;
    if (pkt_valid4)   v4++;
    if (err_parity4)  pe4++;
    if (err_frame4)   fe4++;
    if (err_timeout4) to4++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                           input logic bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk); ps2_data = fr[i];
      repeat (4) @(negedge clk); ps2_clk = 1'b0;
      repeat (4) @(negedge clk); ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bits(mk_frame(b, bad_par, bad_stop), 0, 10);
    ps2_data = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic pkt3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 1'b0, 1'b0);
    send_byte(b, 1'b0, 1'b0);
    send_byte(c, 1'b0, 1'b0);
  endtask

  task automatic pkt4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d);
    pkt3(a, b, c);
    send_byte(d, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rx_en3 = 1'b0; rx_en4 = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    do_reset();
    chk("reset pos_x", pos_x3, 319);
    chk("reset pos_y", pos_y3, 239);
    chk("reset buttons", buttons3, 0);
    chk("reset wheel", wheel3, 0);
    chk("reset ack", ack_seen3, 0);
    chk("reset pulses", {pkt_valid3, err_parity3, err_frame3, err_timeout3}, 0);

    rx_en3 = 1'b1;
    pkt3(8'h08, 8'h05, 8'h03);
    chk("pkt1 valid count", v3, 1);
    chk("pkt1 pos_x", pos_x3, 324);
    chk("pkt1 pos_y", pos_y3, 236);
    chk("pkt1 buttons", buttons3, 0);

    do_reset();
    chk("ack after reset", ack_seen3, 0);
    send_byte(8'hFA, 1'b0, 1'b0);
    chk("ack seen", ack_seen3, 1);
    chk("ack not data", v3, 1);
    pkt3(8'h19, 8'hFB, 8'h00);
    chk("neg dx valid", v3, 2);
    chk("neg dx pos_x", pos_x3, 314);
    chk("neg dx pos_y", pos_y3, 239);
    chk("neg dx buttons", buttons3, 1);

    pkt3(8'h09, 8'hFB, 8'h00);
    chk("pos dx valid", v3, 3);
    chk("pos dx pos_x", pos_x3, 565);

    // Bad parity on byte 1; the trailing byte then fails the header check.
    send_byte(8'h08, 1'b0, 1'b0);
    send_byte(8'h05, 1'b1, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    chk("parity err count", pe3, 1);
    chk("resync frame err", fe3, 1);
    chk("parity no valid", v3, 3);
    chk("parity pos_x held", pos_x3, 565);
    pkt3(8'h08, 8'h01, 8'h01);
    chk("after parity valid", v3, 4);
    chk("after parity pos_x", pos_x3, 566);
    chk("after parity pos_y", pos_y3, 238);

    send_byte(8'h08, 1'b0, 1'b1);
    chk("bad stop frame err", fe3, 2);
    pkt3(8'h0A, 8'h00, 8'h00);
    chk("after stop valid", v3, 5);
    chk("right button", buttons3, 2);

    send_byte(8'h00, 1'b0, 1'b0);
    chk("header bit3 frame err", fe3, 3);
    chk("header bit3 no valid", v3, 5);

    send_bits(mk_frame(8'h08, 1'b0, 1'b0), 0, 3);
    repeat (TO + 50) @(negedge clk);
    ps2_data = 1'b1;
    chk("timeout count", to3, 1);
    chk("timeout no valid", v3, 5);
    pkt3(8'h08, 8'h02, 8'h00);
    chk("after timeout valid", v3, 6);
    chk("after timeout pos_x", pos_x3, 568);

    pkt3(8'h48, 8'h10, 8'h05);
    chk("x overflow pos_x", pos_x3, 568);
    chk("x overflow pos_y", pos_y3, 233);

    do_reset();
    pkt3(8'h18, 8'h80, 8'h00);
    chk("clamp0 step1", pos_x3, 191);
    pkt3(8'h18, 8'h80, 8'h00);
    chk("clamp0 step2", pos_x3, 63);
    pkt3(8'h18, 8'h80, 8'h00);
    chk("clamp0 step3", pos_x3, 0);
    chk("clamp0 pos_y", pos_y3, 239);
    pkt3(8'h28, 8'h00, 8'h80);
    chk("ymax step1", pos_y3, 367);
    pkt3(8'h28, 8'h00, 8'h80);
    chk("ymax step2", pos_y3, 479);
    pkt3(8'h08, 8'hFF, 8'h00);
    pkt3(8'h08, 8'hFF, 8'h00);
    chk("xmax step2", pos_x3, 510);
    pkt3(8'h08, 8'hFF, 8'h00);
    chk("xmax step3", pos_x3, 639);
    chk("3-byte valid total", v3, 15);
    chk("3-byte wheel zero", wheel3, 0);
    chk("no extra timeouts", to3, 1);

    rx_en3 = 1'b0;
    rx_en4 = 1'b1;
    chk("dut4 reset wheel", wheel4, 0);
    pkt4(8'h08, 8'h00, 8'h00, 8'h0F);
    chk("wheel valid", v4, 1);
    chk("wheel value", wheel4, 15);
    chk("wheel pos_x", pos_x4, 319);
    chk("wheel pos_y", pos_y4, 239);

    // Drop rx_en mid-byte, then finish that byte and send a whole packet.
    send_bits(mk_frame(8'h09, 1'b0, 1'b0), 0, 4);
    rx_en4 = 1'b0;
    send_bits(mk_frame(8'h09, 1'b0, 1'b0), 5, 10);
    pkt4(8'h08, 8'h05, 8'h03, 8'h01);
    chk("rx_en low no valid", v4, 1);
    chk("rx_en low no errors", pe4 + fe4 + to4, 0);
    chk("rx_en low wheel held", wheel4, 15);
    chk("rx_en low pos_x held", pos_x4, 319);
    chk("dut3 disabled valid", v3, 15);
    chk("dut3 disabled pos_x", pos_x3, 639);

    rx_en4 = 1'b1;
    repeat (4) @(negedge clk);
    pkt4(8'h08, 8'h05, 8'h03, 8'h01);
    chk("re-enable valid", v4, 2);
    chk("re-enable pos_x", pos_x4, 324);
    chk("re-enable pos_y", pos_y4, 236);
    chk("re-enable wheel", wheel4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
